ste_bus_arbiter: RTL

//  Shares the 68000 bus between the CPU and NREQ alternate masters (0 = GSTMCU floppy/HDD DMA, 1 = blitter).

---
 rtl/ste_bus_pkg.sv | 16 +
 rtl/ste_arb_pick.sv | 34 +++
 rtl/ste_bus_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ste_bus_pkg.sv
// Shared types and constants for the 68000 bus arbiter.
// Imported by the arbiter top and its picker.
package ste_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GRANT   = 3'd2,
    OWNED   = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  localparam int GNT_TMO_DEF = 15;
  localparam int NREQ_MAX    = 4;

endpackage

// File: rtl/ste_arb_pick.sv
// Combinational winner picker.
// Fixed priority (index 0 first) or round-robin after the last owner.
module ste_arb_pick
  import ste_bus_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int OW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last,
  input  logic            rr,
  output logic            any,
  output logic [OW-1:0]   idx
);

  logic w_found;
  int   w_pos;

  assign any = |req;

  always_comb begin
    idx     = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = rr ? (int'(last) + 1 + k) % NREQ : k;
      if (!w_found && req[w_pos]) begin
        idx     = OW'(w_pos);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ste_bus_arbiter.sv
// BR/BG/BGACK arbiter sharing the 68000 bus between the CPU
// and up to four alternate masters, stepped on the 8 MHz enable.
module ste_bus_arbiter
  import ste_bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RR      = 0,
  parameter int GNT_TMO = GNT_TMO_DEF,
  parameter int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk32,
  input  logic            resb,
  input  logic            clk_en,
  input  logic [NREQ-1:0] req_n,
  input  logic [NREQ-1:0] ack_n,
  output logic [NREQ-1:0] gnt_n,
  output logic            cpu_br_n,
  input  logic            cpu_bg_n,
  input  logic            cpu_as_n,
  output logic            bgack_n,
  output logic [OW-1:0]   owner,
  output logic            owner_valid,
  output logic            bus_free,
  output logic            tmo_err
);

  localparam int TW = (GNT_TMO <= 15) ? 4 : $clog2(GNT_TMO + 1);
  localparam logic [TW:0] TMO_LIM = GNT_TMO[TW:0];

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [NREQ-1:0] r_gnt_n;
  logic [NREQ-1:0] w_gnt_nxt;
  logic            r_br_n;
  logic            w_br_nxt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   w_owner_nxt;
  logic [OW-1:0]   r_last;
  logic [OW-1:0]   w_last_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_tmo;
  logic            w_tmo_nxt;

  logic [NREQ-1:0] w_req;
  logic            w_any;
  logic [OW-1:0]   w_pick;
  logic            w_own_req;
  logic            w_own_ack;
  logic            w_tmo_hit;

  assign w_req     = ~req_n;
  assign w_own_req = w_req[r_owner];
  assign w_own_ack = ~ack_n[r_owner];
  // Fires on the tick where the incremented count would reach the limit.
  assign w_tmo_hit = ({1'b0, r_timer} + 1'b1) >= TMO_LIM;

  ste_arb_pick #(
    .NREQ(NREQ),
    .OW  (OW)
  ) u_pick (
    .req (w_req),
    .last(r_last),
    .rr  (RR != 0),
    .any (w_any),
    .idx (w_pick)
  );

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_n;
    w_br_nxt    = r_br_n;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_timer_nxt = r_timer;
    w_tmo_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = REQ;
          w_br_nxt    = 1'b0;
          w_owner_nxt = w_pick;
        end
      end
      REQ: begin
        if (!w_own_req) begin
          if (w_any) w_owner_nxt = w_pick;
          else       w_state_nxt = RELEASE;
        end else if (!cpu_bg_n && cpu_as_n) begin
          w_state_nxt        = GRANT;
          w_gnt_nxt          = '1;
          w_gnt_nxt[r_owner] = 1'b0;
          w_timer_nxt        = '0;
        end
      end
      GRANT: begin
        if (cpu_bg_n) begin
          w_state_nxt = REQ;
          w_gnt_nxt   = '1;
        end else if (w_own_ack) begin
          w_state_nxt = OWNED;
          w_gnt_nxt   = '1;
          w_br_nxt    = 1'b1;
          w_last_nxt  = r_owner;
        end else if (w_tmo_hit) begin
          w_state_nxt = RELEASE;
          w_gnt_nxt   = '1;
          w_tmo_nxt   = 1'b1;
        end else if (r_timer != '1) begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      OWNED: begin
        if (!w_own_ack) begin
          w_state_nxt = RELEASE;
          // Keep BR low across back-to-back ownerships.
          w_br_nxt    = !w_any;
        end
      end
      RELEASE: begin
        if (w_any) begin
          w_state_nxt = REQ;
          w_br_nxt    = 1'b0;
          w_owner_nxt = w_pick;
        end else begin
          w_state_nxt = IDLE;
          w_br_nxt    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_valid_nxt = (w_state_nxt == GRANT) || (w_state_nxt == OWNED);
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      r_gnt_n <= '1;
      r_br_n  <= 1'b1;
      r_owner <= '0;
      r_last  <= OW'(NREQ - 1);
      r_timer <= '0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= clk_en & w_tmo_nxt;
      if (clk_en) begin
        r_gnt_n <= w_gnt_nxt;
        r_br_n  <= w_br_nxt;
        r_owner <= w_owner_nxt;
        r_last  <= w_last_nxt;
        r_timer <= w_timer_nxt;
        r_valid <= w_valid_nxt;
      end
    end
  end

  assign gnt_n       = r_gnt_n;
  assign cpu_br_n    = r_br_n;
  assign owner       = r_owner;
  assign owner_valid = r_valid;
  assign tmo_err     = r_tmo;
  assign bgack_n     = &ack_n;
  assign bus_free    = (r_state == IDLE) && cpu_bg_n;

endmodule
